chip_host_sequencer: RTL and testbench
======================================

# chip_host_sequencer

Host-side initiator for the matmul chip pin protocol, the counterpart that drives the chip's `en`/`write`/`load`/`AUX` pins. On one `start` pulse it performs the full transaction:
- streams 32 operand bytes into the chip (8 registers × 4 elements);
- issues LOAD and waits for the interrupt;
- issues MATMUL and waits for the interrupt;
- reads back 16 result bytes (4 registers × 4 elements).

It sits between a host-side operand buffer/result sink and the chip's external pins, replacing the hand-written stimulus sequence with synthesizable RTL.

## Interface
- `SETUP_CYC`, 2: cycles `en` is held low with address and data stable before each strobe (min 2).
- `STROBE_CYC`, 3: cycles `en` is held high per byte strobe (min 1).
- `TIMEOUT_CYC`, 1024: max cycles to wait for the interrupt in LOAD or MATMUL.
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; ignored while `busy`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at transaction end.
- `err`  out  1  timeout flag; valid with `done`, held until next accepted `start`.
- `op_addr`  out  5  operand buffer address {reg[2:0], idx[1:0]}.
- `op_data`  in  8  operand byte, valid 1 cycle after `op_addr`.
- `res_valid`  out  1  one-cycle pulse per result byte.
- `res_addr`  out  4  result index {reg[1:0], idx[1:0]}.
- `res_data`  out  8  result byte.
- `en`  out  1  chip strobe.
- `write`  out  1  chip mode bit.
- `load`  out  1  chip mode bit.
- `reg_select`  out  3  chip register select.
- `idx_select`  out  2  chip element select.
- `data_in`  out  8  byte to chip.
- `data_out`  in  8  byte from chip.
- `interrupt_pin`  in  1  chip completion, asynchronous.

## Operation
- Mode encoding {write, load}:
  - 10: WRITE operands.
  - 01: LOAD to register file.
  - 00: MATMUL.
  - 11: READ results.
- States: IDLE → WR_SETUP ⇄ WR_STROBE → LD_ARM → LD_WAIT → MM_ARM → MM_WAIT → RD_SETUP ⇄ RD_STROBE → DONE → IDLE.
- The `err` path: LD_WAIT or MM_WAIT → DONE when the timeout expires; `err` = 1 and the READ phase is skipped.
- WR_SETUP:
  - `en` = 0, `reg_select`/`idx_select` = byte counter, `op_addr` = counter.
  - `data_in` captures `op_data` on the 2nd setup cycle.
- WR_STROBE:
  - `en` = 1 for `STROBE_CYC` cycles, all other pins stable.
  - Counter increments; after byte 31, go to LD_ARM.
- LD_ARM / MM_ARM:
  - Mode pins change with `en` = 0 for `SETUP_CYC` cycles, then `en` = 1.
  - `en` stays high through the WAIT state.
- WAIT states:
  - Completion is a rising edge of the synchronized `interrupt_pin`. A level high left over from the previous phase does not count.
  - The timeout counter counts from entry into the WAIT state.
- RD_SETUP / RD_STROBE:
  - Same shaping as WRITE, over counter 0–15, with `reg_select` = {0, cnt[3:2]}.
  - `res_data` samples `data_out` on the last strobe cycle; `res_valid` pulses the next cycle.
- Reset (any state, asynchronous):
  - Outputs go to 0: `en`, `write`, `load`, selects, `data_in`, `op_addr`, `busy`, `done`, `err`, `res_*`.
  - State returns to IDLE; no partial transaction resumes.
- `start` in the same cycle as `done` is ignored; it is accepted from IDLE only.

## Timing
- Per byte: `SETUP_CYC` + `STROBE_CYC` cycles, so 5 by default.
- WRITE phase: 160 cycles. READ phase: 80 cycles.
- Each ARM phase: `SETUP_CYC` cycles.
- Interrupt detection latency: 3 cycles after the pin rises (2-flop sync + edge register).
- `done`: 1 cycle after the last `res_valid`, or 1 cycle after the timeout.
- Pin changes occur only while `en` = 0, except `en` itself.

## Structure
- Package `chip_host_pkg` holds:
  - state enum;
  - mode encodings `MODE_WRITE`/`MODE_LOAD`/`MODE_MATMUL`/`MODE_READ`;
  - `NUM_OPERAND_BYTES` = 32 and `NUM_RESULT_BYTES` = 16.
- Sub-module `pin_sync`: 2-flop synchronizer with async active-low reset, used for `interrupt_pin`.
- One FSM, one byte counter, one shared phase/timeout counter.

## Test plan
- Operands A = {0,2,3,1},{0,2,0,3},{1,2,4,4},{0,2,4,2} and Wᵀ = {2,2,0,0},{2,4,4,0},{4,1,4,1},{2,4,1,4} → chip model receives 32 bytes in order; each strobe is exactly 3 cycles high, preceded by 2 low cycles.
- Chip model raises interrupt 5 cycles after LOAD and 12 after MATMUL → exactly one mode change per phase; `res_addr` runs 0..15 with `res_data` = model value (0xA0 + addr); `done` pulses once and `err` = 0.
- Interrupt held high from LOAD into MATMUL, then low, then re-raised 12 cycles later → MM_WAIT ends only on the new rising edge.
- Interrupt never asserted in MATMUL → `done` with `err` = 1 after 1024 wait cycles; no `res_valid` pulses.
- `rst_n` asserted during byte 17 of WRITE → all outputs 0 asynchronously; after a new `start`, the transaction restarts at byte 0.
- `start` pulsed while `busy`, and again in the same cycle as `done` → both ignored; only one transaction runs.

Source files
------------

// File: rtl/chip_host_sequencer_pkg.sv
// Shared types and constants for the matmul chip host sequencer.
// Mode encodings are the {write, load} pin pair driven toward the chip.
package chip_host_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_SETUP,
        S_WR_STROBE,
        S_LD_ARM,
        S_LD_WAIT,
        S_MM_ARM,
        S_MM_WAIT,
        S_RD_SETUP,
        S_RD_STROBE,
        S_DONE
    } state_e;

    localparam logic [1:0] MODE_WRITE  = 2'b10;
    localparam logic [1:0] MODE_LOAD   = 2'b01;
    localparam logic [1:0] MODE_MATMUL = 2'b00;
    localparam logic [1:0] MODE_READ   = 2'b11;

    localparam int NUM_OPERAND_BYTES = 32;
    localparam int NUM_RESULT_BYTES  = 16;

endpackage

// File: rtl/chip_host_sequencer_if.sv
// Pin bundle between the host sequencer (master) and the matmul chip (slave).
interface chip_host_sequencer_if;
    logic       en;
    logic       write;
    logic       load;
    logic [2:0] reg_select;
    logic [1:0] idx_select;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       interrupt_pin;

    modport master (
        output en, write, load, reg_select, idx_select, data_in,
        input  data_out, interrupt_pin
    );

    modport slave (
        input  en, write, load, reg_select, idx_select, data_in,
        output data_out, interrupt_pin
    );
endinterface

// File: rtl/chip_host_sequencer_pin_sync.sv
// Multi-flop synchronizer for an asynchronous input pin.
module pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];
endmodule

// File: rtl/chip_host_sequencer.sv
// Host-side initiator for the matmul chip: writes 32 operands, runs LOAD and
// MATMUL with interrupt handshakes, then reads 16 result bytes back.
module chip_host_sequencer
    import chip_host_pkg::*;
#(
    parameter int SETUP_CYC   = 2,
    parameter int STROBE_CYC  = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [4:0]                  op_addr,
    input  logic [7:0]                  op_data,
    output logic                        res_valid,
    output logic [3:0]                  res_addr,
    output logic [7:0]                  res_data,
    chip_host_sequencer_if.master       pins
);
    localparam int PHASE_W = $clog2(TIMEOUT_CYC + 1);

    state_e             state_reg, state_next;
    logic [4:0]         cnt_reg, cnt_next, cnt_inc;
    logic [PHASE_W-1:0] phase_reg, phase_next;
    logic               en_reg, en_next;
    logic [1:0]         mode_reg, mode_next;
    logic [2:0]         reg_sel_reg, reg_sel_next;
    logic [1:0]         idx_sel_reg, idx_sel_next;
    logic [7:0]         data_in_reg, data_in_next;
    logic [4:0]         op_addr_reg, op_addr_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               err_reg, err_next;
    logic               res_valid_reg, res_valid_next;
    logic [3:0]         res_addr_reg, res_addr_next;
    logic [7:0]         res_data_reg, res_data_next;

    logic irq_sync, irq_d_reg, irq_rise_reg;
    logic setup_last, strobe_last, timeout_last;

    pin_sync #(.STAGES(2)) u_irq_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pins.interrupt_pin),
        .q     (irq_sync)
    );

    // Registered edge so only a fresh rising edge ends a WAIT state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_d_reg    <= 1'b0;
            irq_rise_reg <= 1'b0;
        end else begin
            irq_d_reg    <= irq_sync;
            irq_rise_reg <= irq_sync & ~irq_d_reg;
        end
    end

    assign cnt_inc      = cnt_reg + 5'd1;
    assign setup_last   = (phase_reg == PHASE_W'(SETUP_CYC - 1));
    assign strobe_last  = (phase_reg == PHASE_W'(STROBE_CYC - 1));
    assign timeout_last = (phase_reg == PHASE_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            phase_reg     <= '0;
            en_reg        <= 1'b0;
            mode_reg      <= 2'b00;
            reg_sel_reg   <= '0;
            idx_sel_reg   <= '0;
            data_in_reg   <= '0;
            op_addr_reg   <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            res_valid_reg <= 1'b0;
            res_addr_reg  <= '0;
            res_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            phase_reg     <= phase_next;
            en_reg        <= en_next;
            mode_reg      <= mode_next;
            reg_sel_reg   <= reg_sel_next;
            idx_sel_reg   <= idx_sel_next;
            data_in_reg   <= data_in_next;
            op_addr_reg   <= op_addr_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            res_valid_reg <= res_valid_next;
            res_addr_reg  <= res_addr_next;
            res_data_reg  <= res_data_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        phase_next     = phase_reg + PHASE_W'(1);
        en_next        = en_reg;
        mode_next      = mode_reg;
        reg_sel_next   = reg_sel_reg;
        idx_sel_next   = idx_sel_reg;
        data_in_next   = data_in_reg;
        op_addr_next   = op_addr_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        err_next       = err_reg;
        res_valid_next = 1'b0;
        res_addr_next  = res_addr_reg;
        res_data_next  = res_data_reg;

        case (state_reg)
            S_IDLE: begin
                phase_next = '0;
                // done_reg high means we are in the done cycle: start is dropped.
                if (start && !done_reg) begin
                    state_next   = S_WR_SETUP;
                    busy_next    = 1'b1;
                    err_next     = 1'b0;
                    cnt_next     = '0;
                    mode_next    = MODE_WRITE;
                    reg_sel_next = '0;
                    idx_sel_next = '0;
                    op_addr_next = '0;
                end
            end
            S_WR_SETUP: begin
                if (setup_last) begin
                    data_in_next = op_data;
                    en_next      = 1'b1;
                    phase_next   = '0;
                    state_next   = S_WR_STROBE;
                end
            end
            S_WR_STROBE: begin
                if (strobe_last) begin
                    en_next    = 1'b0;
                    phase_next = '0;
                    if (cnt_reg == 5'(NUM_OPERAND_BYTES - 1)) begin
                        mode_next  = MODE_LOAD;
                        state_next = S_LD_ARM;
                    end else begin
                        cnt_next                     = cnt_inc;
                        op_addr_next                 = cnt_inc;
                        {reg_sel_next, idx_sel_next} = cnt_inc;
                        state_next                   = S_WR_SETUP;
                    end
                end
            end
            S_LD_ARM, S_MM_ARM: begin
                if (setup_last) begin
                    en_next    = 1'b1;
                    phase_next = '0;
                    state_next = (state_reg == S_LD_ARM) ? S_LD_WAIT : S_MM_WAIT;
                end
            end
            S_LD_WAIT, S_MM_WAIT: begin
                if (irq_rise_reg) begin
                    en_next    = 1'b0;
                    phase_next = '0;
                    if (state_reg == S_LD_WAIT) begin
                        mode_next  = MODE_MATMUL;
                        state_next = S_MM_ARM;
                    end else begin
                        mode_next    = MODE_READ;
                        cnt_next     = '0;
                        reg_sel_next = '0;
                        idx_sel_next = '0;
                        state_next   = S_RD_SETUP;
                    end
                end else if (timeout_last) begin
                    en_next    = 1'b0;
                    err_next   = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_RD_SETUP: begin
                if (setup_last) begin
                    en_next    = 1'b1;
                    phase_next = '0;
                    state_next = S_RD_STROBE;
                end
            end
            S_RD_STROBE: begin
                if (strobe_last) begin
                    en_next        = 1'b0;
                    phase_next     = '0;
                    res_valid_next = 1'b1;
                    res_addr_next  = cnt_reg[3:0];
                    res_data_next  = pins.data_out;
                    if (cnt_reg == 5'(NUM_RESULT_BYTES - 1)) begin
                        state_next = S_DONE;
                    end else begin
                        cnt_next     = cnt_inc;
                        reg_sel_next = {1'b0, cnt_inc[3:2]};
                        idx_sel_next = cnt_inc[1:0];
                        state_next   = S_RD_SETUP;
                    end
                end
            end
            S_DONE: begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                phase_next = '0;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy            = busy_reg;
    assign done            = done_reg;
    assign err             = err_reg;
    assign op_addr         = op_addr_reg;
    assign res_valid       = res_valid_reg;
    assign res_addr        = res_addr_reg;
    assign res_data        = res_data_reg;
    assign pins.en         = en_reg;
    assign pins.write      = mode_reg[1];
    assign pins.load       = mode_reg[0];
    assign pins.reg_select = reg_sel_reg;
    assign pins.idx_select = idx_sel_reg;
    assign pins.data_in    = data_in_reg;
endmodule

// File: tb/tb_chip_host_sequencer.sv
// Directed bench for chip_host_sequencer with a behavioural chip model,
// an operand buffer and scoreboards for written operands and read results.
module tb_chip_host_sequencer;
    import chip_host_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy, done, err;
    logic [4:0] op_addr;
    logic [7:0] op_data;
    logic       res_valid;
    logic [3:0] res_addr;
    logic [7:0] res_data;
    logic       irq;

    chip_host_sequencer_if pins();

    chip_host_sequencer #(
        .SETUP_CYC   (2),
        .STROBE_CYC  (3),
        .TIMEOUT_CYC (1024)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .op_addr   (op_addr),
        .op_data   (op_data),
        .res_valid (res_valid),
        .res_addr  (res_addr),
        .res_data  (res_data),
        .pins      (pins)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests_run = 0;
    int fails     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    // Operand buffer: A rows in registers 0..3, W-transpose rows in 4..7.
    logic [7:0] op_mem [32];
    always @(posedge clk) op_data <= op_mem[op_addr];

    // Chip model state
    logic [1:0]  mode, mode_prev, held_mode;
    logic [12:0] held_pins;
    logic        en_prev, first_rise, rv_prev;
    int          scenario, low_cnt, high_cnt, mm_high;
    int          en_rises, mode_changes, done_pulses, res_count;
    logic [12:0] wr_q [$];
    logic [11:0] res_q [$];

    assign mode               = {pins.write, pins.load};
    assign pins.data_out      = (mode == MODE_READ) ?
                                (8'hA0 + {4'h0, pins.reg_select[1:0], pins.idx_select}) : 8'h00;
    assign pins.interrupt_pin = irq;

    always @(negedge clk) begin
        if (!rst_n) begin
            en_prev   = 1'b0;
            irq       = 1'b0;
            mode_prev = mode;
            rv_prev   = 1'b0;
        end else begin
            if (mode !== mode_prev) mode_changes++;
            mode_prev = mode;
            if (done) begin
                done_pulses++;
                check("done_after_last_res", rv_prev, (scenario != 2));
            end
            if (pins.en) begin
                if (!en_prev) begin
                    en_rises++;
                    if (!first_rise) check("setup_low_cycles", low_cnt, 2);
                    first_rise = 1'b0;
                    held_mode  = mode;
                    held_pins  = {pins.reg_select, pins.idx_select, pins.data_in};
                    high_cnt   = 0;
                    if (mode == MODE_WRITE) begin
                        check("wr_pending", (wr_q.size() > 0), 1);
                        if (wr_q.size() > 0) check("wr_byte", held_pins, wr_q.pop_front());
                    end
                end else begin
                    check("pins_stable_while_en",
                          {mode, pins.reg_select, pins.idx_select, pins.data_in},
                          {held_mode, held_pins});
                end
                high_cnt++;
                if (mode == MODE_LOAD && high_cnt == 5) irq = 1'b1;
                if (mode == MODE_MATMUL) begin
                    mm_high++;
                    if (scenario == 0 && high_cnt == 12) irq = 1'b1;
                    if (scenario == 1 && high_cnt == 8)  irq = 1'b0;
                    if (scenario == 1 && high_cnt == 20) irq = 1'b1;
                end
            end else begin
                if (en_prev) begin
                    if (held_mode == MODE_WRITE || held_mode == MODE_READ)
                        check("strobe_high_cycles", high_cnt, 3);
                    if (!(held_mode == MODE_LOAD && scenario == 1)) irq = 1'b0;
                    low_cnt = 0;
                end
                low_cnt++;
            end
            en_prev = pins.en;
            if (res_valid) begin
                res_count++;
                check("res_pending", (res_q.size() > 0), 1);
                if (res_q.size() > 0) check("res_byte", {res_addr, res_data}, res_q.pop_front());
            end
            rv_prev = res_valid;
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_status"}, {busy, done, err, res_valid, res_addr, res_data, op_addr}, 0);
        check({tag, "_pins"}, {pins.en, pins.write, pins.load, pins.reg_select,
                               pins.idx_select, pins.data_in}, 0);
    endtask

    task automatic launch(input int scen, input bit with_results);
        scenario = scen;
        for (int i = 0; i < NUM_OPERAND_BYTES; i++) wr_q.push_back({5'(i), op_mem[i]});
        if (with_results)
            for (int a = 0; a < NUM_RESULT_BYTES; a++) res_q.push_back({4'(a), 8'hA0 + 8'(a)});
        mode_changes = 0; en_rises = 0; done_pulses = 0; res_count = 0; mm_high = 0;
        first_rise = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("err_cleared_on_start", err, 0);
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("done_within_bound", done, 1);
    endtask

    task automatic finish_txn(input string name, input bit exp_err, input int exp_rises,
                              input int exp_res, input int exp_modes);
        repeat (5) @(negedge clk);
        check({name, "_done_pulses"}, done_pulses, 1);
        check({name, "_err"}, err, exp_err);
        check({name, "_busy_idle"}, busy, 0);
        check({name, "_en_rises"}, en_rises, exp_rises);
        check({name, "_res_count"}, res_count, exp_res);
        check({name, "_mode_changes"}, mode_changes, exp_modes);
        check({name, "_queues_drained"}, wr_q.size() + res_q.size(), 0);
        $display("[TB] txn %s: err=%0d en_rises=%0d results=%0d mm_wait=%0d",
                 name, err, en_rises, res_count, mm_high);
    endtask

    initial begin
        int cyc;
        op_mem = '{8'd0, 8'd2, 8'd3, 8'd1,  8'd0, 8'd2, 8'd0, 8'd3,
                   8'd1, 8'd2, 8'd4, 8'd4,  8'd0, 8'd2, 8'd4, 8'd2,
                   8'd2, 8'd2, 8'd0, 8'd0,  8'd2, 8'd4, 8'd4, 8'd0,
                   8'd4, 8'd1, 8'd4, 8'd1,  8'd2, 8'd4, 8'd1, 8'd4};
        scenario = 0;
        irq      = 1'b0;
        start    = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_state");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Normal run; start pulses while busy and during done must be ignored.
        launch(0, 1'b1);
        repeat (40) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_txn("normal", 1'b0, 50, 16, 4);
        repeat (15) @(negedge clk);
        check("start_in_done_ignored_busy", busy, 0);
        check("start_in_done_ignored_rises", en_rises, 50);

        // Interrupt level held from LOAD into MATMUL; only the new edge counts.
        launch(1, 1'b1);
        wait_done();
        finish_txn("held_irq", 1'b0, 50, 16, 4);
        check("mm_waits_for_new_edge", (mm_high >= 20), 1);

        // MATMUL interrupt never arrives.
        launch(2, 1'b0);
        wait_done();
        finish_txn("timeout", 1'b1, 34, 0, 3);
        check("timeout_wait_cycles", mm_high, 1024);
        repeat (10) @(negedge clk);
        check("err_held", err, 1);

        // Asynchronous reset in the middle of operand byte 17.
        launch(0, 1'b1);
        cyc = 0;
        while (!(pins.en && {pins.reg_select, pins.idx_select} == 5'd17) && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_byte17", {pins.en, pins.reg_select, pins.idx_select}, {1'b1, 5'd17});
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("async_reset");
        wr_q.delete();
        res_q.delete();
        repeat (3) @(negedge clk);
        check_outputs_zero("held_in_reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", busy, 0);
        launch(0, 1'b1);
        wait_done();
        finish_txn("after_reset", 1'b0, 50, 16, 4);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
